// File: rtl/jesd_snapshot_capture.sv
// jesd_snapshot_capture: armed/triggered burst capture of the JESD dout stream into RAM with readback
module jesd_snapshot_capture #(
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 10,
    parameter int STAMP_W = 32
) (
    input  logic              dsp_clk,
    input  logic              dsp_areset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sync,
    input  logic              arm,
    input  logic              trig_sw,
    input  logic              use_sync_trig,
    input  logic [ADDR_W:0]   capture_len,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              armed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [STAMP_W-1:0] trig_stamp
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d, word_count_q, word_count_d, len_norm, wc_inc;
    logic [STAMP_W-1:0]  trig_stamp_q, trig_stamp_d, beat_q, beat_d;
    logic                pend_q, pend_d, rd_vld_q, trig_beat, we;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    // Trigger qualification, length normalisation and RAM write enable
    always_comb begin
        trig_beat = din_vld & (pend_q | trig_sw | (use_sync_trig & din_sync));
        len_norm  = (capture_len == '0 || capture_len > FULL) ? FULL : capture_len;
        wc_inc    = word_count_q + ONE;
        we        = !arm && din_vld && ((state_q == ARMED && trig_beat) || state_q == CAPTURE);
    end
    // Next state: arm always restarts; the beat that reaches len finishes the burst
    always_comb begin
        state_d = state_q;
        if (arm)
            state_d = ARMED;
        else if (state_q == ARMED && trig_beat)
            state_d = (len_q == ONE) ? DONE : CAPTURE;
        else if (state_q == CAPTURE && din_vld && wc_inc == len_q)
            state_d = DONE;
    end
    // Datapath next values: length, word count, pending sw trigger, stamp, beat counter, readback
    always_comb begin
        len_d        = len_q;
        word_count_d = word_count_q;
        pend_d       = pend_q;
        trig_stamp_d = trig_stamp_q;
        beat_d       = beat_q + {{(STAMP_W-1){1'b0}}, din_vld};
        rd_data_d    = rd_en ? mem[rd_addr] : rd_data_q;
        if (arm) begin
            len_d        = len_norm;
            word_count_d = '0;
            pend_d       = 1'b0;
        end else if (state_q == ARMED) begin
            pend_d = trig_beat ? 1'b0 : (pend_q | trig_sw);
            if (trig_beat) begin
                word_count_d = wc_inc;
                trig_stamp_d = beat_q;
            end
        end else if (we) begin
            word_count_d = wc_inc;
        end
    end
    // Status outputs decoded from state
    always_comb begin
        armed = state_q == ARMED;
        busy  = state_q == ARMED || state_q == CAPTURE;
        done  = state_q == DONE;
    end
    // State and datapath registers
    always_ff @(posedge dsp_clk or negedge dsp_areset_n) begin
        if (!dsp_areset_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_count_q <= '0;
            pend_q       <= 1'b0;
            trig_stamp_q <= '0;
            beat_q       <= '0;
            rd_data_q    <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            pend_q       <= pend_d;
            trig_stamp_q <= trig_stamp_d;
            beat_q       <= beat_d;
            rd_data_q    <= rd_data_d;
            rd_vld_q     <= rd_en;
        end
    end
    // Capture RAM write port, never reset; in ARMED word_count is zero so the trigger word lands at 0
    always_ff @(posedge dsp_clk) begin
        if (we)
            mem[word_count_q[ADDR_W-1:0]] <= din;
    end
    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_vld_q;
    assign word_count  = word_count_q;
    assign trig_stamp  = trig_stamp_q;
endmodule

// File: tb/tb_jesd_snapshot_capture.sv
// tb_jesd_snapshot_capture: vector table, directed sequences and random stimulus against a capture model
module tb_jesd_snapshot_capture;
    logic         dsp_clk = 1'b0;
    logic         dsp_areset_n;
    logic [511:0] din;
    logic         din_vld, din_sync, arm, trig_sw, use_sync_trig, rd_en;
    logic [10:0]  capture_len;
    logic [9:0]   rd_addr;
    logic [511:0] rd_data;
    logic         rd_data_vld, armed, busy, done;
    logic [10:0]  word_count;
    logic [31:0]  trig_stamp;

    int n_vec = 0;
    int n_err = 0;

    // model: whether an arm has happened, whether its trigger has fired, words captured so far
    bit           m_active, m_trig, m_pend, m_rd_known, m_rd_vld;
    int           m_len, m_cnt;
    logic [31:0]  m_beat, m_stamp;
    logic [511:0] m_mem [1024];
    bit           m_known [1024];
    logic [511:0] m_rd;

    typedef struct {
        bit vld, sync, arm, trig, use_sync;
        logic [10:0] len;
        bit e_armed, e_busy, e_done;
        int e_wc, e_stamp;
    } vec_t;
    vec_t tbl [11];

    jesd_snapshot_capture dut (
        .dsp_clk(dsp_clk), .dsp_areset_n(dsp_areset_n), .din(din), .din_vld(din_vld),
        .din_sync(din_sync), .arm(arm), .trig_sw(trig_sw), .use_sync_trig(use_sync_trig),
        .capture_len(capture_len), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .rd_data_vld(rd_data_vld), .armed(armed), .busy(busy), .done(done),
        .word_count(word_count), .trig_stamp(trig_stamp)
    );

    always #5 dsp_clk = ~dsp_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [511:0] pat(int j);
        return {16{32'(j * 7 + 32'h1000)}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_trig = 0; m_pend = 0; m_cnt = 0; m_len = 0;
        m_beat = 0; m_stamp = 0; m_rd = '0; m_rd_known = 1; m_rd_vld = 0;
    endtask

    task automatic put(input logic [511:0] d);
        m_mem[m_cnt] = d;
        m_known[m_cnt] = 1;
        m_cnt++;
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_step();
        if (rd_en) begin
            m_rd = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
        end
        m_rd_vld = rd_en;
        if (arm) begin
            m_active = 1; m_trig = 0; m_pend = 0; m_cnt = 0;
            m_len = (capture_len == 0 || capture_len > 1024) ? 1024 : int'(capture_len);
        end else if (m_active && !m_trig) begin
            if (din_vld && (m_pend || trig_sw || (use_sync_trig && din_sync))) begin
                m_trig = 1; m_pend = 0; m_stamp = m_beat;
                put(din);
            end else if (trig_sw) begin
                m_pend = 1;
            end
        end else if (m_active && m_cnt < m_len && din_vld) begin
            put(din);
        end
        m_beat += 32'(din_vld);
    endtask

    task automatic check_model();
        chk("armed", armed, m_active && !m_trig);
        chk("busy", busy, m_active && (!m_trig || m_cnt < m_len));
        chk("done", done, m_active && m_trig && m_cnt == m_len);
        chk("word_count", word_count, m_cnt);
        chk("trig_stamp", trig_stamp, m_stamp);
        chk("rd_data_vld", rd_data_vld, m_rd_vld);
        if (m_rd_known) chk("rd_data", rd_data, m_rd);
    endtask

    task automatic tick();
        model_step();
        @(posedge dsp_clk);
        #1;
        check_model();
    endtask

    task automatic drive(input bit v, input bit s, input bit a, input bit t, input logic [511:0] d);
        din_vld = v; din_sync = s; arm = a; trig_sw = t; din = d;
    endtask

    task automatic do_reset();
        #3;
        dsp_areset_n = 0;
        #2;
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_trig_stamp", trig_stamp, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_data_vld", rd_data_vld, 0);
        model_reset();
        @(posedge dsp_clk);
        #1;
        dsp_areset_n = 1;
    endtask

    initial begin
        dsp_areset_n = 1;
        drive(0, 0, 0, 0, '0);
        use_sync_trig = 0; capture_len = 0; rd_addr = 0; rd_en = 0;
        tbl[0]  = '{0,0,0,0,0,11'd0, 0,0,0, 0,0};
        tbl[1]  = '{0,0,0,1,0,11'd0, 0,0,0, 0,0};
        tbl[2]  = '{0,0,1,0,0,11'd1, 1,1,0, 0,0};
        tbl[3]  = '{1,1,0,1,1,11'd1, 0,0,1, 1,0};
        tbl[4]  = '{1,0,0,1,1,11'd1, 0,0,1, 1,0};
        tbl[5]  = '{0,0,1,0,0,11'd2, 1,1,0, 0,0};
        tbl[6]  = '{1,1,0,0,0,11'd2, 1,1,0, 0,0};
        tbl[7]  = '{0,0,0,1,0,11'd2, 1,1,0, 0,0};
        tbl[8]  = '{1,0,0,0,0,11'd2, 0,1,0, 1,3};
        tbl[9]  = '{0,0,0,0,0,11'd2, 0,1,0, 1,3};
        tbl[10] = '{1,0,0,0,0,11'd2, 0,0,1, 2,3};
        @(posedge dsp_clk);
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].vld, tbl[i].sync, tbl[i].arm, tbl[i].trig, 512'(1000 + i));
            use_sync_trig = tbl[i].use_sync;
            capture_len = tbl[i].len;
            tick();
            chk($sformatf("tbl%0d_armed", i), armed, tbl[i].e_armed);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("tbl%0d_wc", i), word_count, tbl[i].e_wc);
            chk($sformatf("tbl%0d_stamp", i), trig_stamp, tbl[i].e_stamp);
        end
        drive(0, 0, 0, 0, '0);
        use_sync_trig = 0;

        // sync-triggered ramp capture from a fresh beat count
        do_reset();
        use_sync_trig = 1; capture_len = 8;
        drive(0, 0, 1, 0, '0); tick();
        for (int k = 0; k <= 10; k++) begin
            drive(1, k == 3, 0, 0, 512'(k));
            tick();
        end
        drive(0, 0, 0, 0, '0); tick();
        chk("ramp_done", done, 1);
        chk("ramp_wc", word_count, 8);
        chk("ramp_stamp", trig_stamp, 3);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; rd_addr = 10'(i);
            tick();
            chk("ramp_rd", rd_data, 512'(i + 3));
            chk("ramp_rd_vld", rd_data_vld, 1);
        end
        rd_en = 0; tick();
        chk("ramp_rd_vld_low", rd_data_vld, 0);
        chk("ramp_rd_hold", rd_data, 512'(10));
        use_sync_trig = 0;

        // reset in the middle of a capture, then capture again from address 0
        capture_len = 16;
        drive(0, 0, 1, 0, '0); tick();
        drive(1, 0, 0, 1, rnd512()); tick();
        for (int j = 0; j < 4; j++) begin
            drive(1, 0, 0, 0, rnd512()); tick();
        end
        chk("mid_wc", word_count, 5);
        do_reset();
        capture_len = 4;
        drive(0, 0, 1, 0, '0); tick();
        for (int j = 0; j < 4; j++) begin
            drive(1, 0, 0, 1, 512'(500 + j)); tick();
        end
        drive(0, 0, 0, 0, '0);
        chk("post_rst_done", done, 1);
        chk("post_rst_wc", word_count, 4);
        rd_en = 1; rd_addr = 0; tick();
        chk("post_rst_rd0", rd_data, 512'(500));
        rd_en = 0;

        // full-depth capture via capture_len=0, sw trigger while idle, half-rate beats
        capture_len = 0;
        drive(0, 0, 1, 0, '0); tick();
        drive(0, 0, 0, 1, '0); tick();
        for (int j = 0; j < 1024; j++) begin
            drive(0, 0, 0, 0, '0); tick();
            if (j == 1023) chk("full_not_done_early", done, 0);
            drive(1, 0, 0, 0, pat(j)); tick();
        end
        drive(0, 0, 0, 0, '0);
        chk("full_done", done, 1);
        chk("full_wc", word_count, 1024);
        rd_en = 1; rd_addr = 1023; tick();
        chk("full_rd1023", rd_data, pat(1023));
        rd_addr = 0; tick();
        chk("full_rd0", rd_data, pat(0));
        rd_en = 0;

        // arm during capture with a simultaneous valid beat
        capture_len = 8;
        drive(0, 0, 1, 0, '0); tick();
        drive(1, 0, 0, 1, 512'hA); tick();
        drive(1, 0, 0, 0, 512'hB); tick();
        drive(1, 0, 0, 0, 512'hC); tick();
        chk("rearm_wc3", word_count, 3);
        drive(1, 0, 1, 0, 512'hD); tick();
        chk("rearm_armed", armed, 1);
        chk("rearm_wc0", word_count, 0);
        drive(0, 0, 0, 0, '0);
        rd_en = 1; rd_addr = 3; tick();
        chk("rearm_no_write", rd_data, pat(3));
        rd_en = 0;
        drive(1, 0, 0, 1, 512'hE); tick();
        for (int j = 0; j < 7; j++) begin
            drive(1, 0, 0, 0, rnd512()); tick();
        end
        drive(0, 0, 0, 0, '0);
        chk("rearm_done", done, 1);

        // sw trigger in DONE is forgotten; read-first on a colliding write
        drive(0, 0, 0, 1, '0); tick();
        capture_len = 2;
        drive(0, 0, 1, 0, '0); tick();
        drive(1, 0, 0, 0, 512'h77); tick();
        chk("done_trig_ignored", armed, 1);
        rd_en = 1; rd_addr = 0;
        drive(1, 0, 0, 1, 512'hF); tick();
        chk("read_first_old", rd_data, 512'hE);
        drive(0, 0, 0, 0, '0); tick();
        chk("read_first_new", rd_data, 512'hF);
        rd_en = 0;

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 15) == 0, rnd512());
            if ($urandom_range(0, 31) == 0) use_sync_trig = $urandom_range(0, 1);
            capture_len = ($urandom_range(0, 7) == 0) ? 11'($urandom()) : 11'($urandom_range(0, 12));
            rd_en = $urandom_range(0, 1);
            rd_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom()) : 10'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
